system_sequencer: RTL and testbench

SYSTEM_SEQUENCER -- requirements
Module: system_sequencer

---
 rtl/system_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_system_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_sequencer.sv
// Serialising sequencer for FENCE / FENCE.I / SYSTEM / illegal instructions: drain, act, flush.
// Optional FENCE.I strobe is enabled by defining SYS_SEQ_FENCE_I_EN.
module system_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        is_misc_mem_i,
  input  logic        is_system_i,
  input  logic        e_illegal_inst_i,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic        pipe_empty_i,
  input  logic        dmem_busy_i,
  input  logic        irq_pending_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        csr_en_o,
  output logic        mret_o,
  output logic        trap_o,
  output logic        fence_i_o,
  output logic [3:0]  cause_o,
  output logic        busy_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_EXEC  = 3'd2,
    S_WFI   = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_MISC = 2'd1,
    C_SYS  = 2'd2,
    C_ILL  = 2'd3
  } cls_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [2:0]  funct3_q;
  logic [11:0] csr_addr_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;
  logic        trigger;

  logic        act_trap, act_csr, act_mret, act_wfi;
  logic [3:0]  act_cause;
`ifdef SYS_SEQ_FENCE_I_EN
  logic        act_fence_i;
  logic        fence_i_d;
`endif

  assign trigger = valid_i & (is_misc_mem_i | is_system_i | e_illegal_inst_i);

  // Class priority when several decoder flags are raised together.
  always_comb begin
    cls_d = C_NONE;
    if (e_illegal_inst_i)   cls_d = C_ILL;
    else if (is_system_i)   cls_d = C_SYS;
    else if (is_misc_mem_i) cls_d = C_MISC;
  end

  // Action taken in EXEC, decoded from the captured instruction fields.
  always_comb begin
    act_trap  = 1'b0;
    act_cause = 4'd0;
    act_csr   = 1'b0;
    act_mret  = 1'b0;
    act_wfi   = 1'b0;
`ifdef SYS_SEQ_FENCE_I_EN
    act_fence_i = 1'b0;
`endif
    case (cls_q)
      C_ILL: begin
        act_trap  = 1'b1;
        act_cause = 4'd2;
      end
      C_SYS: begin
        if (funct3_q == 3'b000) begin
          case (csr_addr_q)
            12'h000: begin act_trap = 1'b1; act_cause = 4'd11; end
            12'h001: begin act_trap = 1'b1; act_cause = 4'd3;  end
            12'h302: act_mret = 1'b1;
            12'h105: act_wfi  = 1'b1;
            default: begin act_trap = 1'b1; act_cause = 4'd2;  end
          endcase
        end else if (funct3_q == 3'b100) begin
          act_trap  = 1'b1;
          act_cause = 4'd2;
        end else begin
          act_csr = 1'b1;
        end
      end
      C_MISC: begin
        if (funct3_q == 3'b001) begin
`ifdef SYS_SEQ_FENCE_I_EN
          act_fence_i = 1'b1;
`endif
        end else if (funct3_q != 3'b000) begin
          act_trap  = 1'b1;
          act_cause = 4'd2;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    stall_o  = 1'b1;
    flush_o  = 1'b0;
    csr_en_o = 1'b0;
    mret_o   = 1'b0;
    trap_o   = 1'b0;
    cause_o  = 4'd0;
    busy_o   = 1'b1;
`ifdef SYS_SEQ_FENCE_I_EN
    fence_i_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        busy_o  = 1'b0;
        // Gated by reset so a live trigger cannot raise stall while held in reset.
        stall_o = trigger & rst_ni;
        if (trigger) begin
          capture = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pipe_empty_i && !dmem_busy_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        csr_en_o = act_csr;
        mret_o   = act_mret;
        trap_o   = act_trap;
        cause_o  = act_cause;
`ifdef SYS_SEQ_FENCE_I_EN
        fence_i_d = act_fence_i;
`endif
        if (act_wfi) begin
          state_d = S_WFI;
        end else begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      S_WFI: begin
        if (irq_pending_i) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SYS_SEQ_FENCE_I_EN
  assign fence_i_o = fence_i_d;
`else
  assign fence_i_o = 1'b0;
`endif

  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      cls_q      <= C_NONE;
      funct3_q   <= 3'd0;
      csr_addr_q <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        cls_q      <= cls_d;
        funct3_q   <= funct3_i;
        csr_addr_q <= csr_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_system_sequencer.sv
// Bench for system_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_system_sequencer;

  localparam int FC = 2;
`ifdef SYS_SEQ_FENCE_I_EN
  localparam bit FENCE_I_ON = 1'b1;
`else
  localparam bit FENCE_I_ON = 1'b0;
`endif

  typedef logic [10:0] vec_t;

  logic        clk, rst_n;
  logic        valid, misc, sys, ill;
  logic [2:0]  f3;
  logic [11:0] csr;
  logic        pe, db, irq;
  logic        stall_o, flush_o, csr_en_o, mret_o, trap_o, fence_i_o, busy_o;
  logic [3:0]  cause_o;
  logic [2:0]  dbg_state;

  system_sequencer #(.FLUSH_CYCLES(FC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .is_misc_mem_i(misc),
    .is_system_i(sys), .e_illegal_inst_i(ill), .funct3_i(f3), .csr_addr_i(csr),
    .pipe_empty_i(pe), .dmem_busy_i(db), .irq_pending_i(irq),
    .stall_o(stall_o), .flush_o(flush_o), .csr_en_o(csr_en_o), .mret_o(mret_o),
    .trap_o(trap_o), .fence_i_o(fence_i_o), .cause_o(cause_o), .busy_o(busy_o),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  vec_t exp_q[$];
  int   wait_kind = 0;   // 0: none, 1: awaiting drained pipe, 2: awaiting interrupt
  vec_t pend_exec;
  logic pend_wfi;
  vec_t last_vec;

  function automatic vec_t mk(input logic st, input logic fl, input logic ce, input logic mr,
                              input logic tr, input logic fi, input logic [3:0] ca, input logic bz);
    return {st, fl, ce, mr, tr, fi, ca, bz};
  endfunction

  function automatic vec_t dut_vec();
    return {stall_o, flush_o, csr_en_o, mret_o, trap_o, fence_i_o, cause_o, busy_o};
  endfunction

  // What the instruction must do once the pipeline is drained.
  function automatic void decide(input logic i_ill, input logic i_sys, input logic [2:0] i_f3,
                                 input logic [11:0] i_csr, output vec_t v, output logic wfi);
    logic tr, ce, mr, fi;
    logic [3:0] ca;
    tr = 0; ce = 0; mr = 0; fi = 0; ca = 0; wfi = 0;
    if (i_ill) begin
      tr = 1; ca = 2;
    end else if (i_sys) begin
      if (i_f3 == 3'd0) begin
        if (i_csr == 12'h000)      begin tr = 1; ca = 11; end
        else if (i_csr == 12'h001) begin tr = 1; ca = 3; end
        else if (i_csr == 12'h302) mr = 1;
        else if (i_csr == 12'h105) wfi = 1;
        else                       begin tr = 1; ca = 2; end
      end else if (i_f3 == 3'd4) begin
        tr = 1; ca = 2;
      end else begin
        ce = 1;
      end
    end else begin
      if (i_f3 == 3'd1)      fi = FENCE_I_ON;
      else if (i_f3 != 3'd0) begin tr = 1; ca = 2; end
    end
    v = mk(1, 0, ce, mr, tr, fi, ca, 1);
  endfunction

  task automatic push_flush();
    for (int i = 0; i < FC; i++) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 4'd0, 1));
  endtask

  task automatic check_lit(input string name, input vec_t act, input vec_t expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, expv);
    end
  endtask

  // driver + per-cycle compare against the model
  task automatic step(input logic i_v, input logic i_m, input logic i_s, input logic i_i,
                      input logic [2:0] i_f3, input logic [11:0] i_csr,
                      input logic i_pe, input logic i_db, input logic i_irq);
    vec_t e;
    logic trig;
    @(negedge clk);
    valid = i_v; misc = i_m; sys = i_s; ill = i_i; f3 = i_f3; csr = i_csr;
    pe = i_pe; db = i_db; irq = i_irq;
    #1;
    trig = i_v & (i_m | i_s | i_i);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else if (wait_kind == 1) begin
      e = mk(1, 0, 0, 0, 0, 0, 4'd0, 1);
      if (i_pe && !i_db) begin
        exp_q.push_back(pend_exec);
        if (pend_wfi) wait_kind = 2;
        else begin push_flush(); wait_kind = 0; end
      end
    end else if (wait_kind == 2) begin
      e = mk(1, 0, 0, 0, 0, 0, 4'd0, 1);
      if (i_irq) begin push_flush(); wait_kind = 0; end
    end else begin
      e = mk(trig, 0, 0, 0, 0, 0, 4'd0, 0);
      if (trig) begin
        decide(i_i, i_s, i_f3, i_csr, pend_exec, pend_wfi);
        wait_kind = 1;
      end
    end
    last_vec = dut_vec();
    checks++;
    if (last_vec !== e) begin
      failures++;
      $display("FAIL cycle_outputs cyc=%0d got=%b expected=%b", cyc, last_vec, e);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'd0, 12'd0, 1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1; sys = 1; misc = 1; f3 = 3'd1; pe = 1; db = 0; irq = 1;
    #1;
    check_lit("reset_outputs_async", dut_vec(), 11'd0);
    exp_q.delete();
    wait_kind = 0;
    @(posedge clk);
    #1;
    check_lit("reset_outputs_held", dut_vec(), 11'd0);
    valid = 0; sys = 0; misc = 0; ill = 0; irq = 0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 0; valid = 0; misc = 0; sys = 0; ill = 0; f3 = 0; csr = 0;
    pe = 1; db = 0; irq = 0;
    #12;
    check_lit("reset_initial", dut_vec(), 11'd0);
    #5 rst_n = 1;

    // CSRRW, pipe already empty; trigger held high through the last flush cycle
    step(1, 0, 1, 0, 3'd1, 12'h340, 1, 0, 0);
    check_lit("csrrw_c0", last_vec, mk(1, 0, 0, 0, 0, 0, 4'd0, 0));
    idle(1);
    check_lit("csrrw_drain", last_vec, mk(1, 0, 0, 0, 0, 0, 4'd0, 1));
    idle(1);
    check_lit("csrrw_exec", last_vec, mk(1, 0, 1, 0, 0, 0, 4'd0, 1));
    idle(1);
    check_lit("csrrw_flush1", last_vec, mk(1, 1, 0, 0, 0, 0, 4'd0, 1));
    step(1, 0, 1, 0, 3'd1, 12'h340, 1, 0, 0);
    check_lit("csrrw_flush2", last_vec, mk(1, 1, 0, 0, 0, 0, 4'd0, 1));
    idle(1);
    check_lit("csrrw_idle", last_vec, mk(0, 0, 0, 0, 0, 0, 4'd0, 0));
    idle(2);

    // ECALL with data memory busy for 4 cycles
    step(1, 0, 1, 0, 3'd0, 12'h000, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 3'd0, 12'd0, 1, 1, 0);
      check_lit("ecall_wait", last_vec, mk(1, 0, 0, 0, 0, 0, 4'd0, 1));
    end
    idle(1);
    idle(1);
    check_lit("ecall_exec", last_vec, mk(1, 0, 0, 0, 1, 0, 4'd11, 1));
    idle(3);

    // WFI, interrupt arrives ten cycles later
    step(1, 0, 1, 0, 3'd0, 12'h105, 1, 0, 0);
    idle(1);
    idle(1);
    check_lit("wfi_exec", last_vec, mk(1, 0, 0, 0, 0, 0, 4'd0, 1));
    for (int i = 0; i < 9; i++) idle(1);
    step(0, 0, 0, 0, 3'd0, 12'd0, 1, 0, 1);
    check_lit("wfi_irq", last_vec, mk(1, 0, 0, 0, 0, 0, 4'd0, 1));
    idle(1);
    check_lit("wfi_flush", last_vec, mk(1, 1, 0, 0, 0, 0, 4'd0, 1));
    idle(3);

    // illegal wins over system; SYSTEM funct3=100
    step(1, 0, 1, 1, 3'd1, 12'h300, 1, 0, 0);
    idle(2);
    check_lit("illegal_prio", last_vec, mk(1, 0, 0, 0, 1, 0, 4'd2, 1));
    idle(3);
    step(1, 0, 1, 0, 3'd4, 12'h000, 1, 0, 0);
    idle(2);
    check_lit("sys_f3_100", last_vec, mk(1, 0, 0, 0, 1, 0, 4'd2, 1));
    idle(3);

    // FENCE.I
    step(1, 1, 0, 0, 3'd1, 12'h000, 1, 0, 0);
    idle(2);
    check_lit("fence_i_exec", last_vec, mk(1, 0, 0, 0, 0, FENCE_I_ON, 4'd0, 1));
    idle(1);
    check_lit("fence_i_flush", last_vec, mk(1, 1, 0, 0, 0, 0, 4'd0, 1));
    idle(3);

    // reset during DRAIN
    step(1, 0, 1, 0, 3'd0, 12'h302, 0, 0, 0);
    step(0, 0, 0, 0, 3'd0, 12'd0, 0, 0, 0);
    do_reset();
    idle(4);
    check_lit("post_reset_drain", last_vec, 11'd0);
    step(1, 0, 1, 0, 3'd0, 12'h302, 1, 0, 0);
    idle(2);
    check_lit("mret_after_reset", last_vec, mk(1, 0, 0, 1, 0, 0, 4'd0, 1));
    idle(3);

    // reset during first FLUSH cycle
    step(1, 1, 0, 0, 3'd0, 12'h000, 1, 0, 0);
    idle(2);
    do_reset();
    idle(3);
    check_lit("post_reset_flush", last_vec, 11'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic rv, rm, rs, ri, rpe, rdb, rirq;
      logic [2:0] rf3;
      logic [11:0] rcsr;
      int k;
      if ($urandom_range(0, 399) == 0) do_reset();
      rv = ($urandom_range(0, 9) < 4);
      rm = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 2) == 0);
      ri = ($urandom_range(0, 5) == 0);
      rf3 = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      k = $urandom_range(0, 4);
      case (k)
        0: rcsr = 12'h000;
        1: rcsr = 12'h001;
        2: rcsr = 12'h302;
        3: rcsr = 12'h105;
        default: rcsr = 12'($urandom_range(0, 4095));
      endcase
      rpe  = ($urandom_range(0, 3) != 0);
      rdb  = ($urandom_range(0, 4) == 0);
      rirq = ($urandom_range(0, 9) == 0);
      step(rv, rm, rs, ri, rf3, rcsr, rpe, rdb, rirq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
